// File: rtl/ksa.sv
// ksa: ARC4 key-scheduling permutation over a shared single-port 256-byte S RAM.
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   en     - start request, accepted while rdy=1
//   rdy    - idle and ready for en
//   key    - 8*KEYLEN-bit key, byte 0 in the MSBs, latched on accept
//   addr   - S RAM address
//   rddata - S RAM read data, valid the cycle after addr with wren=0
//   wrdata - S RAM write data
//   wren   - S RAM write enable
module ksa #(
   parameter int KEYLEN = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   output logic                rdy,
   input  logic [8*KEYLEN-1:0] key,
   output logic [7:0]          addr,
   input  logic [7:0]          rddata,
   output logic [7:0]          wrdata,
   output logic                wren
);
   localparam int KW = KEYLEN > 1 ? $clog2(KEYLEN) : 1;
   typedef enum logic [2:0] {IDLE, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J} state_t;
   state_t              state_q;
   logic [8*KEYLEN-1:0] key_q, key_sh;
   logic [7:0]          i_q, j_q, si_q, sj_q, j_d;
   logic [KW-1:0]       kidx_q, kidx_d;
   // shifting the selected key byte to the top avoids a computed part-select
   assign key_sh = key_q << {kidx_q, 3'b000};
   assign j_d    = j_q + rddata + key_sh[8*KEYLEN-1 -: 8];
   assign kidx_d = (kidx_q == KW'(KEYLEN - 1)) ? '0 : kidx_q + 1'b1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rdy     <= 1'b1;
         addr    <= '0;
         wrdata  <= '0;
         wren    <= 1'b0;
         key_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         kidx_q  <= '0;
         si_q    <= '0;
         sj_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (en) begin
               rdy     <= 1'b0;
               key_q   <= key;
               i_q     <= '0;
               j_q     <= '0;
               kidx_q  <= '0;
               addr    <= '0;
               wren    <= 1'b0;
               state_q <= RD_I;
            end
            RD_I: state_q <= GET_I;
            GET_I: begin
               si_q    <= rddata;
               j_q     <= j_d;
               addr    <= j_d;
               state_q <= RD_J;
            end
            RD_J: state_q <= GET_J;
            GET_J: begin
               sj_q    <= rddata;
               addr    <= i_q;
               wrdata  <= rddata;
               wren    <= 1'b1;
               state_q <= WR_I;
            end
            WR_I: begin
               addr    <= j_q;
               wrdata  <= si_q;
               state_q <= WR_J;
            end
            WR_J: begin
               wren <= 1'b0;
               if (i_q == 8'hff) begin
                  rdy     <= 1'b1;
                  addr    <= '0;
                  state_q <= IDLE;
               end else begin
                  i_q     <= i_q + 1'b1;
                  kidx_q  <= kidx_d;
                  addr    <= i_q + 1'b1;
                  state_q <= RD_I;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
